// File: rtl/image_window_buffer.sv
// image_window_buffer
//   Raster-order multi-channel pixel stream in, KxK sliding windows out.
//   K-1 circular line buffers (one per stored row) feed a KxK window shift
//   register. Only windows lying fully inside the frame and aligned to STRIDE
//   in both directions are emitted, one clock after the completing pixel.
//
//   Optional build macro: WINDOW_POS_EN
//     defined   -> adds out_row/out_col, the top-left frame coordinate of the
//                  window currently on window_out.
//     undefined -> those ports and their registers do not exist.
//
//   Handshake: a pixel transfers on a clock edge where data_in_valid and
//   data_in_ready are both 1; a window transfers where out_valid and
//   out_ready are both 1. data_in_ready = !out_valid | out_ready, so input
//   stalls exactly while an un-consumed window is held; there is no skid
//   buffer. out_valid never drops without out_ready, and window_out is
//   stable while out_valid & !out_ready.
module image_window_buffer #(
  parameter int DATA_SIZE   = 8,
  parameter int ROW_SIZE    = 28,
  parameter int COL_SIZE    = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1,
  parameter int STRIDE      = 1
) (
  input  logic                                                     clock,
  input  logic                                                     reset_n,
  input  logic [CHANNELS*DATA_SIZE-1:0]                            pixel_data_in,
  input  logic                                                     data_in_valid,
  output logic                                                     data_in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_SIZE-1:0]    window_out,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic                                                     frame_done
`ifdef WINDOW_POS_EN
  ,
  output logic [$clog2(COL_SIZE)-1:0]                              out_row,
  output logic [$clog2(ROW_SIZE)-1:0]                              out_col
`endif
);

  localparam int K   = KERNEL_SIZE;
  localparam int PW  = CHANNELS * DATA_SIZE;
  localparam int WW  = K * K * PW;
  localparam int CW  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW  = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(COL_SIZE - 1);
  localparam logic [CW-1:0]  COL_WIN0 = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_WIN0 = RW'(K - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(STRIDE - 1);

  // Raster position of the pixel that will be accepted next.
  logic [CW-1:0]  col_cnt;
  logic [RW-1:0]  row_cnt;
  // Distance (mod STRIDE) from the first window-completing column/row.
  // Held at 0 until the counter reaches K-1, so the first full window in
  // each row and in each frame is always aligned.
  logic [PHW-1:0] col_phase;
  logic [PHW-1:0] row_phase;

  logic accept;
  logic col_wrap;
  logic window_hit;

  // Row 0 is the oldest stored row; row K-2 the most recent full row.
  logic [PW-1:0] line_buf [K-1][ROW_SIZE];
  // Incoming column: K-1 stored samples at col_cnt plus the new pixel.
  logic [PW-1:0] new_col  [K];
  // Window shift register, [row][col], col K-1 is the newest column.
  logic [PW-1:0] win_q    [K][K];
  logic [PW-1:0] win_d    [K][K];
  logic [WW-1:0] win_flat;

  assign data_in_ready = !out_valid | out_ready;
  assign accept        = data_in_valid & data_in_ready;
  assign col_wrap      = (col_cnt == COL_LAST);

  // A window completes on an accepted pixel that lies at or beyond (K-1,K-1)
  // and is stride-aligned in both directions.
  assign window_hit = accept
                    && (row_cnt >= ROW_WIN0) && (col_cnt >= COL_WIN0)
                    && (row_phase == '0) && (col_phase == '0);

  // Gather the new right-hand column of the window.
  always_comb begin
    for (int r = 0; r < K; r++) new_col[r] = '0;
    for (int r = 0; r < K - 1; r++) new_col[r] = line_buf[r][col_cnt];
    new_col[K-1] = pixel_data_in;
  end

  // Next window contents: shift left by one column, insert new_col at right.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = new_col[r];
    end
  end

  // Flatten the next window into the output bit layout (r, c, ch).
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) win_flat[(r*K+c)*PW +: PW] = win_d[r][c];
    end
  end

  // Line buffers shift up one row at the shared column address; no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < K - 1; i++) line_buf[i][col_cnt] <= new_col[i+1];
    end
  end

  // Window shift register advances on every accepted pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Column counter and column stride phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt   <= '0;
      col_phase <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_cnt   <= '0;
        col_phase <= '0;
      end else begin
        col_cnt <= col_cnt + CW'(1);
        if (col_cnt < COL_WIN0) col_phase <= '0;
        else if (col_phase == PH_LAST) col_phase <= '0;
        else col_phase <= col_phase + PHW'(1);
      end
    end
  end

  // Row counter and row stride phase, stepped on column wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt   <= '0;
      row_phase <= '0;
    end else if (accept && col_wrap) begin
      if (row_cnt == ROW_LAST) begin
        row_cnt   <= '0;
        row_phase <= '0;
      end else begin
        row_cnt <= row_cnt + RW'(1);
        if (row_cnt < ROW_WIN0) row_phase <= '0;
        else if (row_phase == PH_LAST) row_phase <= '0;
        else row_phase <= row_phase + PHW'(1);
      end
    end
  end

  // End-of-frame pulse, one cycle after the last pixel is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) frame_done <= 1'b0;
    else          frame_done <= accept && col_wrap && (row_cnt == ROW_LAST);
  end

  // Output window register: load on completion, release on out_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      window_out <= '0;
    end else if (window_hit) begin
      out_valid  <= 1'b1;
      window_out <= win_flat;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef WINDOW_POS_EN
  // Top-left coordinate of the emitted window, loaded with window_out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (window_hit) begin
      out_row <= row_cnt - ROW_WIN0;
      out_col <= col_cnt - COL_WIN0;
    end
  end
`endif

endmodule

// File: tb/tb_image_window_buffer.sv
// tb_image_window_buffer
//   Two instances share one stimulus path, selected by 'sel':
//     dut_a : defaults (K=3, C=1, S=1)
//     dut_b : K=3, C=3, S=2 (channel ch sample = base + 100*ch mod 256)
//   Expected windows are computed from a stored copy of the frame and the
//   window-inclusion rules, pushed to exp_q on each accepted pixel, and popped
//   by an independent monitor whenever a window handshake occurs.
//   Build with WINDOW_POS_EN defined to also check out_row/out_col.
module tb_image_window_buffer;

  localparam int D  = 8;
  localparam int RS = 28;
  localparam int CS = 28;
  localparam int K  = 3;
  localparam int WA = K * K * 1 * D;
  localparam int WB = K * K * 3 * D;
  localparam int W  = WB;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus signals ----------------
  logic          sel    = 1'b0;
  logic          valid  = 1'b0;
  logic [7:0]    pix    = '0;
  logic          oready = 1'b1;
  logic          bp_en  = 1'b0;
  logic          gaps   = 1'b0;
  logic [23:0]   pix_b;

  logic          rdy_a, rdy_b, ov_a, ov_b, fd_a, fd_b;
  logic [WA-1:0] win_a;
  logic [WB-1:0] win_b;
`ifdef WINDOW_POS_EN
  logic [4:0]    row_a, col_a, row_b, col_b;
`endif

  assign pix_b = {8'(pix + 8'd200), 8'(pix + 8'd100), pix};

  image_window_buffer dut_a (
    .clock         (clock),
    .reset_n       (reset_n),
    .pixel_data_in (pix),
    .data_in_valid (valid & !sel),
    .data_in_ready (rdy_a),
    .window_out    (win_a),
    .out_valid     (ov_a),
    .out_ready     (oready),
    .frame_done    (fd_a)
`ifdef WINDOW_POS_EN
    ,
    .out_row       (row_a),
    .out_col       (col_a)
`endif
  );

  image_window_buffer #(.CHANNELS(3), .STRIDE(2)) dut_b (
    .clock         (clock),
    .reset_n       (reset_n),
    .pixel_data_in (pix_b),
    .data_in_valid (valid & sel),
    .data_in_ready (rdy_b),
    .window_out    (win_b),
    .out_valid     (ov_b),
    .out_ready     (oready),
    .frame_done    (fd_b)
`ifdef WINDOW_POS_EN
    ,
    .out_row       (row_b),
    .out_col       (col_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [9:0]   exp_pos_q[$];
  int           n_cmp    = 0;
  int           n_mis    = 0;
  int           win_cnt  = 0;
  int           idx      = 0;
  logic         fd_exp   = 1'b0;
  logic         last_hit = 1'b0;
  int           frame_pix [CS][RS];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] chan(input int v, input int ch);
    return 8'((v + 100 * ch) % 256);
  endfunction

  // Reference model: record the pixel, decide from frame coordinates whether
  // a window is complete, and if so build it from the stored frame.
  task automatic model_accept(input int v);
    int r, c, s, nch;
    logic [W-1:0] expv;
    r = idx / RS;
    c = idx % RS;
    s   = sel ? 2 : 1;
    nch = sel ? 3 : 1;
    frame_pix[r][c] = v;
    last_hit = 1'b0;
    if (r >= K-1 && c >= K-1 && (r-K+1) % s == 0 && (c-K+1) % s == 0) begin
      expv = '0;
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          for (int ch = 0; ch < nch; ch++)
            expv[((rr*K+cc)*nch+ch)*D +: D] = chan(frame_pix[r-K+1+rr][c-K+1+cc], ch);
      exp_q.push_back(expv);
      exp_pos_q.push_back({5'(r-K+1), 5'(c-K+1)});
      last_hit = 1'b1;
    end
    if (idx == RS*CS-1) begin
      fd_exp = 1'b1;
      idx = 0;
    end else begin
      idx++;
    end
  endtask

  // ---------------- out_ready driver ----------------
  int hold = 0;
  always @(posedge clock) begin
    #1;
    if (!bp_en) oready = 1'b1;
    else if (hold > 0) begin
      oready = 1'b0;
      hold--;
    end else if ($urandom_range(0, 63) == 0) begin
      oready = 1'b0;
      hold = 4;
    end else begin
      oready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_win   = '0;
  always @(negedge clock) begin
    logic         cov, crdy, cfd, idle_ov;
    logic [W-1:0] cwin, expv;
    logic [9:0]   epos;
    if (reset_n) begin
      cov     = sel ? ov_b : ov_a;
      idle_ov = sel ? ov_a : ov_b;
      crdy    = sel ? rdy_b : rdy_a;
      cfd     = sel ? fd_b : fd_a;
      cwin    = sel ? win_b : W'(win_a);
      check("idle_out_valid", W'(idle_ov), W'(0));
      check("frame_done", W'(cfd), W'(fd_exp));
      fd_exp = 1'b0;
      if (cov) begin
        if (prev_stall) check("hold_window", cwin, prev_win);
        if (!oready) begin
          check("in_ready_stall", W'(crdy), W'(0));
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_window: got %0h required none", cwin);
        end else begin
          expv = exp_q.pop_front();
          epos = exp_pos_q.pop_front();
          check("window", cwin, expv);
`ifdef WINDOW_POS_EN
          check("window_pos", W'(sel ? {row_b, col_b} : {row_a, col_a}), W'(epos));
`endif
          win_cnt++;
        end
        prev_stall = !oready;
        prev_win   = cwin;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    repeat (3) @(posedge clock);
    exp_q.delete();
    exp_pos_q.delete();
    fd_exp     = 1'b0;
    idx        = 0;
    win_cnt    = 0;
    prev_stall = 1'b0;
    @(negedge clock);
    check("rst_out_valid_a", W'(ov_a), W'(0));
    check("rst_out_valid_b", W'(ov_b), W'(0));
    check("rst_frame_done", W'({fd_a, fd_b}), W'(0));
    check("rst_window_a", W'(win_a), W'(0));
    check("rst_window_b", win_b, W'(0));
    check("rst_in_ready", W'({rdy_a, rdy_b}), W'(3));
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    logic acc;
    int   n;
    valid = 1'b1;
    pix   = v;
    acc   = 1'b0;
    n     = 0;
    while (!acc && n <= 200) begin
      @(negedge clock);
      acc = sel ? rdy_b : rdy_a;
      @(posedge clock);
      #1;
      n++;
    end
    valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: got no accept required accept within 200 cycles");
    end else begin
      model_accept(int'(v));
      if (last_hit && !bp_en) begin
        @(negedge clock);
        check("latency_out_valid", W'(sel ? ov_b : ov_a), W'(1));
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clock);
      t++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic run_pixels(input int npix, input logic ramp);
    for (int n = 0; n < npix; n++) begin
      send(ramp ? 8'(idx % 256) : 8'($urandom_range(0, 255)));
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic run_frame(input logic ramp, input int exp_windows);
    run_pixels(RS * CS, ramp);
    drain();
    check("windows_per_frame", W'(win_cnt), W'(exp_windows));
    win_cnt = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    apply_reset();

    // Defaults: ramp frame, no gaps, no backpressure.
    sel = 1'b0; bp_en = 1'b0; gaps = 1'b0;
    run_frame(1'b1, ((CS-K)/1+1)*((RS-K)/1+1));

    // Defaults: random pixels, random gaps, random backpressure incl. long holds.
    bp_en = 1'b1; gaps = 1'b1;
    run_frame(1'b0, ((CS-K)/1+1)*((RS-K)/1+1));

    // Reset after 100 pixels, then a clean ramp frame.
    bp_en = 1'b0; gaps = 1'b0;
    run_pixels(100, 1'b1);
    drain();
    apply_reset();
    run_frame(1'b1, ((CS-K)/1+1)*((RS-K)/1+1));

    // Stride 2, three channels: ramp frame, then random with gaps/backpressure.
    sel = 1'b1;
    run_frame(1'b1, ((CS-K)/2+1)*((RS-K)/2+1));
    bp_en = 1'b1; gaps = 1'b1;
    run_frame(1'b0, ((CS-K)/2+1)*((RS-K)/2+1));
    bp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/image_window_buffer.md
Name: image_window_buffer

Overview:
- Parametrised successor to the single-channel sliding-window image buffer.
- Takes a raster-order stream of multi-channel pixels and holds K-1 full rows in line buffers plus a KxK window register.
- Emits only windows that lie entirely inside the frame, with configurable stride and ready/valid backpressure.
- Sits between the pixel source and the convolution MAC array.

Parameters:
DATA_SIZE, 8, bits per channel sample
ROW_SIZE, 28, pixels per image row (width)
COL_SIZE, 28, rows per frame (height)
KERNEL_SIZE, 3, window edge K (2..ROW_SIZE)
CHANNELS, 1, samples per pixel, packed side by side
STRIDE, 1, window step in both directions (1..KERNEL_SIZE)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
pixel_data_in  in  CHANNELS*DATA_SIZE  channel ch at bits [ch*DATA_SIZE +: DATA_SIZE]
data_in_valid  in  1  pixel_data_in valid
data_in_ready  out  1  block can accept a pixel this cycle
window_out  out  K*K*CHANNELS*DATA_SIZE  window; element (r,c,ch) at [((r*K+c)*CHANNELS+ch)*DATA_SIZE +: DATA_SIZE]; r=0 top (oldest) row, c=0 leftmost
out_valid  out  1  window_out valid
out_ready  in  1  consumer accepts window
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: asynchronous, active-low. Clears col/row counters, stride phase counters, out_valid, frame_done and window_out to 0. Line-buffer RAM is not cleared; its contents are don't-care.
- Accept: accept = data_in_valid & data_in_ready.
  - data_in_ready = !out_valid | out_ready. Purely combinational; no skid buffer.
- Counters: col_cnt advances on each accept and wraps at ROW_SIZE-1 to 0, incrementing row_cnt. row_cnt wraps at COL_SIZE-1 to 0.
- Line buffers:
  - K-1 circular rows of ROW_SIZE entries, sharing one write/read address = col_cnt.
  - On accept, the oldest row's value at col_cnt is shifted out and each row shifts up one.
  - The K-column window shift register loads a new right-hand column: the K-1 stored samples plus the incoming pixel.
- Window emission: a window completes on the accept of pixel (row_cnt, col_cnt) when all of the following hold:
  - row_cnt >= K-1 and col_cnt >= K-1;
  - (row_cnt-K+1) mod STRIDE == 0;
  - (col_cnt-K+1) mod STRIDE == 0.
  - Use phase counters, not dividers.
- Output timing:
  - out_valid rises the cycle after the completing accept; latency is 1 clock.
  - window_out is registered and held stable while out_valid & !out_ready.
  - out_valid clears on out_ready when no new window completes in that cycle.
  - Simultaneous out_ready and a completing accept: the new window replaces the old one and out_valid stays 1.
- Row/frame boundaries:
  - Windows never straddle a row wrap; the column gating suppresses columns 0..K-2 of each row.
  - Stale line-buffer data from the previous frame is never emitted, because row gating restarts at row 0.
- Windows per frame: ((COL_SIZE-K)/STRIDE+1)*((ROW_SIZE-K)/STRIDE+1), integer division.
- frame_done: 1 the cycle after the accept of pixel (COL_SIZE-1, ROW_SIZE-1), 0 otherwise.
- Gaps: data_in_valid gaps of any length have no effect on window contents or order.
- Reset mid-frame: the next accepted pixel is treated as (0,0) and no partially filled window is emitted.

Optional Feature:
WINDOW_POS_EN
- Defined: adds output ports out_row [$clog2(COL_SIZE)-1:0] and out_col [$clog2(ROW_SIZE)-1:0].
  - They carry the top-left frame coordinate of the window on window_out.
  - Registered alongside window_out, same stability rules, reset to 0.
- Undefined: ports and position registers are absent; all other behaviour is identical.

Test Plan:
- Ramp, defaults (K=3, C=1, S=1), pixel = index mod 256, out_ready=1:
  - first out_valid arrives one cycle after pixel 58 is accepted;
  - window rows are {0,1,2}, {28,29,30}, {56,57,58};
  - exactly 676 windows per frame;
  - frame_done pulses once after pixel 783.
- Row-edge suppression, defaults: accepting pixels 84 and 85 (row 3, cols 0,1) produces no out_valid; pixel 86 yields rows {28,29,30}, {56,57,58}, {84,85,86}.
- Backpressure: hold out_ready=0 for 5 cycles while a window is valid:
  - window_out is stable and data_in_ready=0;
  - no pixel is lost or duplicated;
  - the total is still 676 windows with correct values.
- STRIDE=2, K=3:
  - 169 windows per frame;
  - the second window completes on pixel 60 with rows {2,3,4}, {30,31,32}, {58,59,60};
  - with WINDOW_POS_EN, out_row=0 and out_col=2.
- CHANNELS=3: channel 1 sample = channel 0 sample + 100. Every window element for ch 1 equals the ch 0 element + 100 (mod 256), at the specified bit position.
- Reset and gaps:
  - Random data_in_valid gaps give output identical to the gapless run.
  - Asserting reset_n=0 after 100 pixels, then restarting the ramp, gives a first window of {0,1,2}, {28,29,30}, {56,57,58}, with no window emitted earlier.
